cycle_sequencer: RTL and testbench
==================================

// Module: cycle_sequencer
// PURPOSE
// Multicycle control sequencer of the CPU: the consumer side of the 2-bit D_FFEC2-style
// state register. It walks FETCH/DECODE/EXEC/WB, issues per-phase strobes to the PC, IR,
// register file and memory, counts retired instructions, and stops on HALT or memory timeout.
// PARAMETERS
// CNT_W     16   width of retired-instruction counter InstrCnt (wraps modulo 2^CNT_W)
// MAX_WAIT  15   max consecutive MemRdy=0 cycles tolerated in one memory access (1..2^8-1)
// PORTS
// Clk       in   1      clock, all state updates on rising edge
// Clr       in   1      synchronous active-high reset
// Run       in   1      start request, level; sampled only while stopped
// Halt      in   1      decoded HALT instruction, valid in DECODE
// NeedMem   in   1      instruction accesses data memory, valid in DECODE/EXEC
// IsStore   in   1      memory access is a write (qualifies NeedMem)
// NeedWb    in   1      instruction writes the register file
// MemRdy    in   1      memory completes the current access this cycle
// State     out  2      00 FETCH, 01 DECODE, 10 EXEC, 11 WB (registered)
// Running   out  1      sequencer active (registered)
// IrLd      out  1      load IR (combinational)
// PcInc     out  1      increment PC (combinational)
// MemRe     out  1      memory read strobe (combinational)
// MemWe     out  1      memory write strobe (combinational)
// RegWe     out  1      register-file write strobe (combinational)
// Halted    out  1      sticky: stopped by HALT (registered)
// Fault     out  1      sticky: stopped by memory timeout (registered)
// InstrCnt  out  CNT_W  retired instructions (registered)
// BEHAVIOUR
// - Clr=1: next edge State=00, Running=0, Halted=0, Fault=0, InstrCnt=0, wait counter=0;
//   all strobes forced 0 in every cycle Clr=1, regardless of state; Clr overrides Run.
// - Stopped (Running=0): State held 00, strobes 0. Run=1 -> next edge Running=1, State=FETCH,
//   Halted=0, Fault=0; InstrCnt NOT cleared. Run while Running=1 ignored.
// - FETCH: MemRe=1. MemRdy=1 -> IrLd=1, PcInc=1 same cycle, next State=DECODE; else hold.
// - DECODE: no strobes. Halt=1 -> next Running=0, Halted=1, State=00, InstrCnt+1 (HALT retires).
//   Else next State=EXEC. NeedMem/NeedWb/IsStore ignored when Halt=1.
// - EXEC: NeedMem=1 -> MemRe=~IsStore, MemWe=IsStore until MemRdy=1; access completes that
//   cycle. NeedMem=0 -> completes immediately (1 cycle). On completion: NeedWb=1 -> WB,
//   else -> FETCH with InstrCnt+1.
// - WB: RegWe=1 for exactly one cycle, next State=FETCH, InstrCnt+1.
// - Wait counter: increments each FETCH/EXEC-memory cycle with MemRdy=0, cleared on
//   MemRdy=1 or state change. Reaching MAX_WAIT with MemRdy still 0 -> next edge Running=0,
//   Fault=1, State=00; no IrLd/PcInc/RegWe issued for that instruction; InstrCnt unchanged.
// - MemRdy=1 on the exact cycle the counter hits MAX_WAIT: access completes, no fault.
// - MemRe and MemWe never both 1. IrLd/PcInc only in FETCH, RegWe only in WB.
// - Latency: non-memory no-WB instr 3 cycles, with WB 4, memory accesses add wait cycles.
// - InstrCnt wraps all-ones -> 0 without flag.
// - Clr mid-instruction: instruction abandoned, no partial strobes after Clr rises.
// TESTING
// - Clr 2 cycles, Run=1 1 cycle, MemRdy=1, NeedMem=0, NeedWb=1 -> states 00,01,10,11,00; RegWe
//   1 cycle; InstrCnt=1 after 4 cycles.
// - Load (NeedMem=1, IsStore=0) with MemRdy low 3 EXEC cycles -> MemRe high 4 cycles, MemWe 0,
//   then WB; store with IsStore=1 -> MemWe, no MemRe.
// - Halt=1 in DECODE -> Running=0, Halted=1, State=00, strobes 0; Run again -> Halted=0, resumes.
// - MAX_WAIT=15, MemRdy=0 forever in FETCH -> Fault=1 after 15 wait cycles, no IrLd;
//   repeat with MemRdy=1 on 15th cycle -> no Fault, IrLd=1.
// - Clr asserted during EXEC with MemWe=1 -> MemWe=0 same cycle, next State=00, InstrCnt=0.
// - CNT_W=4, run 16 non-WB instructions -> InstrCnt wraps 15 -> 0.

Source files
------------

// File: rtl/cycle_sequencer.sv
// Multicycle CPU control sequencer: FETCH/DECODE/EXEC/WB walk with per-phase strobes and retire count.
// Latency: 3 cycles per non-memory instruction, 4 with writeback, plus one cycle per memory wait.
// Backpressure: MemRdy stalls FETCH/EXEC; MAX_WAIT consecutive stalls stop the sequencer with Fault.
module cycle_sequencer #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Run,
  input  logic             Halt,
  input  logic             NeedMem,
  input  logic             IsStore,
  input  logic             NeedWb,
  input  logic             MemRdy,
  output logic [1:0]       State,
  output logic             Running,
  output logic             IrLd,
  output logic             PcInc,
  output logic             MemRe,
  output logic             MemWe,
  output logic             RegWe,
  output logic             Halted,
  output logic             Fault,
  output logic [CNT_W-1:0] InstrCnt
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_DECODE = 2'b01,
    ST_EXEC   = 2'b10,
    ST_WB     = 2'b11
  } state_t;

  // The access times out on the cycle that would be the MAX_WAIT-th consecutive stall.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_q, state_d;
  logic               running_q, running_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         wait_q, wait_d;

  logic               mem_cyc;
  logic               timeout;

  // A memory access is in flight during FETCH and during EXEC of a memory instruction.
  always_comb begin
    mem_cyc = running_q && ((state_q == ST_FETCH) || ((state_q == ST_EXEC) && NeedMem));
    timeout = mem_cyc && !MemRdy && (wait_q == WAIT_LAST);
  end

  // Next-state logic for the sequencer, status flags, retire counter and wait counter.
  always_comb begin
    state_d   = state_q;
    running_d = running_q;
    halted_d  = halted_q;
    fault_d   = fault_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;

    if (!running_q) begin
      // Idle: park in FETCH; a start request clears the sticky stop reasons but not the count.
      state_d = ST_FETCH;
      wait_d  = '0;
      if (Run) begin
        running_d = 1'b1;
        halted_d  = 1'b0;
        fault_d   = 1'b0;
      end
    end else if (timeout) begin
      // Abandon the instruction without retiring it.
      running_d = 1'b0;
      fault_d   = 1'b1;
      state_d   = ST_FETCH;
      wait_d    = '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (MemRdy) begin
            state_d = ST_DECODE;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        ST_DECODE: begin
          wait_d = '0;
          if (Halt) begin
            // HALT itself counts as a retired instruction.
            running_d = 1'b0;
            halted_d  = 1'b1;
            state_d   = ST_FETCH;
            cnt_d     = cnt_q + CNT_ONE;
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!NeedMem || MemRdy) begin
            wait_d = '0;
            if (NeedWb) begin
              state_d = ST_WB;
            end else begin
              state_d = ST_FETCH;
              cnt_d   = cnt_q + CNT_ONE;
            end
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        default: begin
          wait_d  = '0;
          state_d = ST_FETCH;
          cnt_d   = cnt_q + CNT_ONE;
        end
      endcase
    end
  end

  // State register with synchronous clear; Clr overrides everything including Run.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q   <= ST_FETCH;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
    end
  end

  // Phase strobes decode straight from the current state; Clr kills them in the same cycle.
  always_comb begin
    IrLd  = 1'b0;
    PcInc = 1'b0;
    MemRe = 1'b0;
    MemWe = 1'b0;
    RegWe = 1'b0;
    if (running_q && !Clr) begin
      case (state_q)
        ST_FETCH: begin
          MemRe = 1'b1;
          IrLd  = MemRdy;
          PcInc = MemRdy;
        end
        ST_EXEC: begin
          if (NeedMem) begin
            MemRe = !IsStore;
            MemWe = IsStore;
          end
        end
        ST_WB: begin
          RegWe = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign State    = state_q;
  assign Running  = running_q;
  assign Halted   = halted_q;
  assign Fault    = fault_q;
  assign InstrCnt = cnt_q;

  // Read and write strobes are mutually exclusive by construction.
  a_mem_excl: assert property (@(posedge Clk) !(MemRe && MemWe));

endmodule

// File: tb/tb_cycle_sequencer.sv
module tb_cycle_sequencer;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Clr = 1'b1;
  logic Run = 1'b0;
  logic Halt = 1'b0;
  logic NeedMem = 1'b0;
  logic IsStore = 1'b0;
  logic NeedWb = 1'b0;
  logic MemRdy = 1'b0;

  logic [1:0] State;
  logic       Running, IrLd, PcInc, MemRe, MemWe, RegWe, Halted, Fault;
  logic [3:0] InstrCnt;

  cycle_sequencer #(.CNT_W(4), .MAX_WAIT(15)) dut (
    .Clk(Clk), .Clr(Clr), .Run(Run), .Halt(Halt), .NeedMem(NeedMem),
    .IsStore(IsStore), .NeedWb(NeedWb), .MemRdy(MemRdy),
    .State(State), .Running(Running), .IrLd(IrLd), .PcInc(PcInc),
    .MemRe(MemRe), .MemWe(MemWe), .RegWe(RegWe), .Halted(Halted),
    .Fault(Fault), .InstrCnt(InstrCnt)
  );

  typedef struct packed {
    logic [1:0] st;
    logic       run;
    logic [4:0] strb;  // {IrLd, PcInc, MemRe, MemWe, RegWe}
    logic       halted;
    logic       fault;
    logic [3:0] cnt;
  } obs_t;

  typedef struct packed {
    logic clr, run, halt, needmem, isstore, needwb, memrdy;
  } in_t;

  localparam logic [4:0] S_NONE  = 5'b00000;
  localparam logic [4:0] S_FETCH = 5'b11100;
  localparam logic [4:0] S_RD    = 5'b00100;
  localparam logic [4:0] S_WR    = 5'b00010;
  localparam logic [4:0] S_WB    = 5'b00001;

  obs_t exp_q[$];
  obs_t act_q[$];
  int checks = 0;
  int errors = 0;

  function automatic in_t iv(logic clr, logic run, logic halt, logic nm, logic st, logic nw, logic rdy);
    in_t v;
    v = '{clr: clr, run: run, halt: halt, needmem: nm, isstore: st, needwb: nw, memrdy: rdy};
    return v;
  endfunction

  function automatic obs_t mk(logic [1:0] st, logic run, logic [4:0] strb, logic h, logic f, logic [3:0] cnt);
    obs_t o;
    o = '{st: st, run: run, strb: strb, halted: h, fault: f, cnt: cnt};
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{st: State, run: Running, strb: {IrLd, PcInc, MemRe, MemWe, RegWe},
          halted: Halted, fault: Fault, cnt: InstrCnt};
    return o;
  endfunction

  // One clock: drive inputs after the edge, queue the expected view, capture the DUT mid-cycle.
  task automatic cyc(input in_t v, input obs_t e);
    @(posedge Clk);
    #1;
    Clr = v.clr; Run = v.run; Halt = v.halt; NeedMem = v.needmem;
    IsStore = v.isstore; NeedWb = v.needwb; MemRdy = v.memrdy;
    exp_q.push_back(e);
    @(negedge Clk);
    act_q.push_back(sample());
  endtask

  task automatic test_reset();
    obs_t e, a;
    int n = 0;
    cyc(iv(1,0,0,0,0,0,1), mk(2'd0,0,S_NONE,0,0,4'd0));
    cyc(iv(1,1,0,1,1,0,1), mk(2'd0,0,S_NONE,0,0,4'd0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL reset row %0d: got %b expected %b", n, a, e); end
      n++;
    end
  endtask

  task automatic test_wb();
    obs_t e, a;
    int n = 0;
    cyc(iv(0,1,0,0,0,1,1), mk(2'd0,0,S_NONE,0,0,4'd0));
    cyc(iv(0,0,0,0,0,1,1), mk(2'd0,1,S_FETCH,0,0,4'd0));
    cyc(iv(0,0,0,0,0,1,1), mk(2'd1,1,S_NONE,0,0,4'd0));
    cyc(iv(0,0,0,0,0,1,1), mk(2'd2,1,S_NONE,0,0,4'd0));
    cyc(iv(0,0,0,0,0,1,1), mk(2'd3,1,S_WB,0,0,4'd0));
    cyc(iv(0,0,0,0,0,1,1), mk(2'd0,1,S_FETCH,0,0,4'd1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL wb row %0d: got %b expected %b", n, a, e); end
      n++;
    end
  endtask

  task automatic test_load_store();
    obs_t e, a;
    int n = 0;
    cyc(iv(0,0,0,1,0,1,0), mk(2'd1,1,S_NONE,0,0,4'd1));
    for (int i = 0; i < 3; i++) cyc(iv(0,0,0,1,0,1,0), mk(2'd2,1,S_RD,0,0,4'd1));
    cyc(iv(0,0,0,1,0,1,1), mk(2'd2,1,S_RD,0,0,4'd1));
    cyc(iv(0,0,0,1,0,1,1), mk(2'd3,1,S_WB,0,0,4'd1));
    cyc(iv(0,0,0,1,0,1,1), mk(2'd0,1,S_FETCH,0,0,4'd2));
    cyc(iv(0,0,0,1,1,0,0), mk(2'd1,1,S_NONE,0,0,4'd2));
    cyc(iv(0,0,0,1,1,0,0), mk(2'd2,1,S_WR,0,0,4'd2));
    cyc(iv(0,0,0,1,1,0,1), mk(2'd2,1,S_WR,0,0,4'd2));
    cyc(iv(0,0,0,1,1,0,1), mk(2'd0,1,S_FETCH,0,0,4'd3));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL load_store row %0d: got %b expected %b", n, a, e); end
      n++;
    end
  endtask

  task automatic test_halt();
    obs_t e, a;
    int n = 0;
    cyc(iv(0,0,1,1,0,1,1), mk(2'd1,1,S_NONE,0,0,4'd3));
    cyc(iv(0,0,0,0,0,0,1), mk(2'd0,0,S_NONE,1,0,4'd4));
    cyc(iv(0,0,0,0,0,0,1), mk(2'd0,0,S_NONE,1,0,4'd4));
    cyc(iv(0,1,0,0,0,0,0), mk(2'd0,0,S_NONE,1,0,4'd4));
    cyc(iv(0,0,0,0,0,0,1), mk(2'd0,1,S_FETCH,0,0,4'd4));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL halt row %0d: got %b expected %b", n, a, e); end
      n++;
    end
  endtask

  task automatic test_timeout();
    obs_t e, a;
    int n = 0;
    cyc(iv(0,0,0,0,0,0,0), mk(2'd1,1,S_NONE,0,0,4'd4));
    cyc(iv(0,0,0,0,0,0,0), mk(2'd2,1,S_NONE,0,0,4'd4));
    // Fifteen stalled fetch cycles: the last one trips the timeout.
    for (int i = 0; i < 15; i++) cyc(iv(0,0,0,0,0,0,0), mk(2'd0,1,S_RD,0,0,4'd5));
    cyc(iv(0,1,0,0,0,0,0), mk(2'd0,0,S_NONE,0,1,4'd5));
    // Restart; fourteen stalls then ready on the fifteenth cycle completes the fetch.
    for (int i = 0; i < 14; i++) cyc(iv(0,0,0,0,0,0,0), mk(2'd0,1,S_RD,0,0,4'd5));
    cyc(iv(0,0,0,0,0,0,1), mk(2'd0,1,S_FETCH,0,0,4'd5));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL timeout row %0d: got %b expected %b", n, a, e); end
      n++;
    end
  endtask

  task automatic test_clr_mid();
    obs_t e, a;
    int n = 0;
    cyc(iv(0,0,0,1,1,0,0), mk(2'd1,1,S_NONE,0,0,4'd5));
    cyc(iv(0,0,0,1,1,0,0), mk(2'd2,1,S_WR,0,0,4'd5));
    cyc(iv(1,0,0,1,1,0,0), mk(2'd2,1,S_NONE,0,0,4'd5));
    cyc(iv(0,0,0,0,0,0,1), mk(2'd0,0,S_NONE,0,0,4'd0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL clr_mid row %0d: got %b expected %b", n, a, e); end
      n++;
    end
  endtask

  // Sixteen back-to-back 3-cycle instructions with Run held high (ignored while running).
  task automatic test_wrap();
    obs_t e, a;
    int n = 0;
    cyc(iv(0,1,0,0,0,0,1), mk(2'd0,0,S_NONE,0,0,4'd0));
    for (int i = 0; i < 16; i++) begin
      cyc(iv(0,1,0,0,0,0,1), mk(2'd0,1,S_FETCH,0,0,4'(i)));
      cyc(iv(0,1,0,0,0,0,1), mk(2'd1,1,S_NONE,0,0,4'(i)));
      cyc(iv(0,1,0,0,0,0,1), mk(2'd2,1,S_NONE,0,0,4'(i)));
    end
    cyc(iv(0,0,0,0,0,0,1), mk(2'd0,1,S_FETCH,0,0,4'd0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL wrap row %0d: got %b expected %b", n, a, e); end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_wb();
    test_load_store();
    test_halt();
    test_timeout();
    test_clr_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
